score_keeper: RTL

//  Judgement-to-score stage of the rhythm game. Consumes graded hit events (one per

---
 rtl/rhythm_pkg.sv | 37 +++
 rtl/bcd_digit_add.sv | 30 +++
 rtl/score_keeper.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm game datapath.
// Holds the hit grade encodings, the base point values in packed BCD,
// the score_keeper state type and the default display digit count
// (also used by the seven-segment scanner).
package rhythm_pkg;

    localparam int DIGITS_DEFAULT = 8;

    localparam logic [1:0] GRADE_MISS    = 2'd0;
    localparam logic [1:0] GRADE_GOOD    = 2'd1;
    localparam logic [1:0] GRADE_GREAT   = 2'd2;
    localparam logic [1:0] GRADE_PERFECT = 2'd3;

    // Base points, four BCD digits each
    localparam logic [15:0] BCD_MISS    = 16'h0000;
    localparam logic [15:0] BCD_GOOD    = 16'h0100;
    localparam logic [15:0] BCD_GREAT   = 16'h0200;
    localparam logic [15:0] BCD_PERFECT = 16'h0300;

    typedef enum logic [1:0] {
        SK_IDLE = 2'd0,
        SK_ADD  = 2'd1,
        SK_DONE = 2'd2
    } sk_state_e;

    function automatic logic [15:0] base_points(input logic [1:0] grade);
        logic [15:0] pts;
        case (grade)
            GRADE_GOOD:    pts = BCD_GOOD;
            GRADE_GREAT:   pts = BCD_GREAT;
            GRADE_PERFECT: pts = BCD_PERFECT;
            default:       pts = BCD_MISS;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry.
// Ports:
//   a, b  in  4  BCD digits (0..9)
//   cin   in  1  carry in
//   s     out 4  BCD sum digit
//   cout  out 1  decimal carry out
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_sum;
    logic [4:0] w_adj;

    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        w_adj = w_sum - 5'd10;
        if (w_sum > 5'd9) begin
            s    = w_adj[3:0];
            cout = 1'b1;
        end else begin
            s    = w_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Judgement-to-score stage: turns graded hit events into combo, max combo
// and a packed-BCD score with a combo multiplier. The score is built by
// repeated serial BCD addition, one digit per cycle, through a single
// shared digit adder; score_bcd only changes once a whole hit is summed.
// Ports:
//   clk        in   1          system clock
//   rst        in   1          asynchronous reset, active-low
//   clr        in   1          synchronous clear, active-high
//   hit_valid  in   1          hit event offered
//   hit_grade  in   2          0=MISS 1=GOOD 2=GREAT 3=PERFECT
//   hit_ready  out  1          hit accepted when hit_valid & hit_ready
//   score_bcd  out  4*DIGITS   packed BCD score, digit 0 in [3:0]
//   combo      out  16         current consecutive non-miss count
//   max_combo  out  16         best combo since reset/clear
//   sat        out  1          sticky: score saturated at all 9s
module score_keeper
    import rhythm_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEFAULT,
    parameter int COMBO_STEP = 10,
    parameter int MAX_MULT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  hit_valid,
    input  logic [1:0]            hit_grade,
    output logic                  hit_ready,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [15:0]           combo,
    output logic [15:0]           max_combo,
    output logic                  sat
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = $clog2(MAX_MULT + 1);
    localparam logic [DW-1:0]       LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};

    sk_state_e             r_state;
    logic [4*DIGITS-1:0]   r_acc;
    logic [4*DIGITS-1:0]   r_score;
    logic [15:0]           r_addend;
    logic [RW-1:0]         r_rep;
    logic [DW-1:0]         r_digit;
    logic                  r_carry;
    logic [15:0]           r_combo;
    logic [15:0]           r_max;
    logic                  r_sat;

    logic [3:0]            w_a;
    logic [3:0]            w_b;
    logic [3:0]            w_s;
    logic                  w_cout;
    logic [15:0]           w_step;
    logic [RW-1:0]         w_mult;
    logic [15:0]           w_combo_inc;

    assign hit_ready = (r_state == SK_IDLE) & ~clr;
    assign score_bcd = r_score;
    assign combo     = r_combo;
    assign max_combo = r_max;
    assign sat       = r_sat;

    // Multiplier from the combo held before the current hit
    always_comb begin
        w_step = r_combo / 16'(COMBO_STEP);
        if (w_step >= 16'(MAX_MULT - 1))
            w_mult = RW'(MAX_MULT);
        else
            w_mult = RW'(w_step + 16'd1);
    end

    assign w_combo_inc = (r_combo == 16'hFFFF) ? r_combo : r_combo + 16'd1;

    // Base points only occupy the low four digits; higher digits add zero
    always_comb begin
        w_b = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (int'(r_digit) == k)
                w_b = r_addend[4*k +: 4];
        end
    end

    assign w_a = r_acc[4*int'(r_digit) +: 4];

    bcd_digit_add u_digit_add (
        .a    (w_a),
        .b    (w_b),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= SK_IDLE;
            r_acc    <= '0;
            r_score  <= '0;
            r_addend <= '0;
            r_rep    <= '0;
            r_digit  <= '0;
            r_carry  <= 1'b0;
            r_combo  <= '0;
            r_max    <= '0;
            r_sat    <= 1'b0;
        end else if (clr) begin
            r_state  <= SK_IDLE;
            r_acc    <= '0;
            r_score  <= '0;
            r_addend <= '0;
            r_rep    <= '0;
            r_digit  <= '0;
            r_carry  <= 1'b0;
            r_combo  <= '0;
            r_max    <= '0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                SK_IDLE: begin
                    if (hit_valid) begin
                        if (hit_grade == GRADE_MISS) begin
                            r_combo <= '0;
                        end else begin
                            r_combo  <= w_combo_inc;
                            if (w_combo_inc > r_max)
                                r_max <= w_combo_inc;
                            r_addend <= base_points(hit_grade);
                            r_rep    <= w_mult;
                            r_digit  <= '0;
                            r_carry  <= 1'b0;
                            r_state  <= SK_ADD;
                        end
                    end
                end
                SK_ADD: begin
                    // Once saturated the accumulator is frozen, but the
                    // sequencing still runs so timing stays the same.
                    if (!r_sat)
                        r_acc[4*int'(r_digit) +: 4] <= w_s;
                    if (r_digit == LAST_DIGIT) begin
                        if (!r_sat && w_cout) begin
                            r_acc   <= ALL_NINES;
                            r_sat   <= 1'b1;
                            r_state <= SK_DONE;
                        end else if (r_rep == RW'(1)) begin
                            r_state <= SK_DONE;
                        end else begin
                            r_rep   <= r_rep - RW'(1);
                            r_digit <= '0;
                            r_carry <= 1'b0;
                        end
                    end else begin
                        r_digit <= r_digit + DW'(1);
                        r_carry <= w_cout;
                    end
                end
                SK_DONE: begin
                    r_score <= r_acc;
                    r_state <= SK_IDLE;
                end
                default: r_state <= SK_IDLE;
            endcase
        end
    end

endmodule
